// File: rtl/adder_tree_pkg.sv
// Shared definitions for the 16-input, 4-bit adder tree and its stream feeder.
// Contents:
//   NUM_OPS, OP_W, SUM_W, TREE_LAT, CNT_W : datapath geometry and tree latency
//   IDX_W, WAIT_W                         : counter widths derived from the above
//   feeder_state_t                        : FILL / WAIT / HOLD
//   op_slot(k)                            : bit offset of operand k on the op bus
package adder_tree_pkg;

    localparam int NUM_OPS  = 16;
    localparam int OP_W     = 4;
    localparam int SUM_W    = 8;
    localparam int TREE_LAT = 4;
    localparam int CNT_W    = 16;

    localparam int IDX_W  = $clog2(NUM_OPS);
    localparam int WAIT_W = $clog2(TREE_LAT + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

    // Operand k sits at bits [OP_W*k +: OP_W] of the flattened operand bus.
    function automatic int op_slot(input int k);
        return OP_W * k;
    endfunction

endpackage

// File: rtl/adder_tree_4stage_4bit.sv
// Free-running 16-input, 4-bit pipelined adder tree (no valid signal).
// Four register stages: pair sums, quad sums, octet sums, final sum. The sum of
// inputs that are stable before edge N appears on sum_out after edge N+3.
// Only the final stage is reset; the inner stages carry whatever they held.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (final stage only)
//   inp00 .. inp71      : 16 operands; inpXY is leaf 2*X+Y
//   sum_out             : 8-bit registered sum
module adder_tree_4stage_4bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] inp00,
    input  logic [3:0] inp01,
    input  logic [3:0] inp10,
    input  logic [3:0] inp11,
    input  logic [3:0] inp20,
    input  logic [3:0] inp21,
    input  logic [3:0] inp30,
    input  logic [3:0] inp31,
    input  logic [3:0] inp40,
    input  logic [3:0] inp41,
    input  logic [3:0] inp50,
    input  logic [3:0] inp51,
    input  logic [3:0] inp60,
    input  logic [3:0] inp61,
    input  logic [3:0] inp70,
    input  logic [3:0] inp71,
    output logic [7:0] sum_out
);

    logic [3:0] leaf [16];
    logic [4:0] s1_q [8];
    logic [5:0] s2_q [4];
    logic [6:0] s3_q [2];

    assign leaf[0]  = inp00;
    assign leaf[1]  = inp01;
    assign leaf[2]  = inp10;
    assign leaf[3]  = inp11;
    assign leaf[4]  = inp20;
    assign leaf[5]  = inp21;
    assign leaf[6]  = inp30;
    assign leaf[7]  = inp31;
    assign leaf[8]  = inp40;
    assign leaf[9]  = inp41;
    assign leaf[10] = inp50;
    assign leaf[11] = inp51;
    assign leaf[12] = inp60;
    assign leaf[13] = inp61;
    assign leaf[14] = inp70;
    assign leaf[15] = inp71;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            s1_q[i] <= {1'b0, leaf[2*i]} + {1'b0, leaf[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            s2_q[i] <= {1'b0, s1_q[2*i]} + {1'b0, s1_q[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            s3_q[i] <= {1'b0, s2_q[2*i]} + {1'b0, s2_q[2*i+1]};
        end
        if (reset) begin
            sum_out <= '0;
        end else begin
            sum_out <= {1'b0, s3_q[0]} + {1'b0, s3_q[1]};
        end
    end

endmodule

// File: rtl/adder_tree_feeder_4bit.sv
// Stream-to-tree feeder: collects NUM_OPS operands from a valid/ready stream
// into a held parallel bus for the adder tree, waits out the tree latency,
// captures the sum and offers it on a valid/ready output.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_data     : operand stream in; in_ready high only in FILL
//   op_bus               : held operand bus to the tree, op k at [OP_W*k +: OP_W]
//   tree_sum             : tree sum_out
//   out_valid/out_sum    : captured sum; out_ready completes the handshake
//   busy                 : high whenever not in FILL
//   vec_count            : completed output handshakes, wraps
module adder_tree_feeder_4bit
    import adder_tree_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [OP_W-1:0]          in_data,
    output logic                     in_ready,
    output logic [NUM_OPS*OP_W-1:0]  op_bus,
    input  logic [SUM_W-1:0]         tree_sum,
    output logic                     out_valid,
    output logic [SUM_W-1:0]         out_sum,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         vec_count
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TREE_LAT);

    feeder_state_t             state_q, state_d;
    logic [IDX_W-1:0]          op_idx_q, op_idx_d;
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic [NUM_OPS*OP_W-1:0]   op_bus_q, op_bus_d;
    logic                      out_valid_q, out_valid_d;
    logic [SUM_W-1:0]          out_sum_q, out_sum_d;
    logic [CNT_W-1:0]          vec_count_q, vec_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            op_idx_q    <= '0;
            wait_cnt_q  <= '0;
            op_bus_q    <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            op_idx_q    <= op_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            op_bus_q    <= op_bus_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            vec_count_q <= vec_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_idx_d    = op_idx_q;
        wait_cnt_d  = wait_cnt_q;
        op_bus_d    = op_bus_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        vec_count_d = vec_count_q;

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    op_bus_d[op_slot(int'(op_idx_q)) +: OP_W] = in_data;
                    if (op_idx_q == LAST_IDX) begin
                        op_idx_d   = '0;
                        wait_cnt_d = WAIT_INIT;
                        state_d    = WAIT;
                    end else begin
                        op_idx_d = op_idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                // The tree only sees a complete, stable vector once the last
                // slot is written, so its output is trusted after the full
                // latency has elapsed and sampled on this single edge only.
                if (wait_cnt_q == '0) begin
                    out_sum_d   = tree_sum;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    vec_count_d = vec_count_q + 1'b1;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // in_ready is masked by reset so upstream never sees a handshake that the
    // reset-held registers would drop.
    assign in_ready  = (state_q == FILL) && !reset;
    assign busy      = (state_q != FILL);
    assign op_bus    = op_bus_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign vec_count = vec_count_q;

endmodule
